mw8080_rom_ram_map: RTL
=======================

# mw8080_rom_ram_map

Parametrised program-memory block for the Midway/Taito 8080 cores: a configurable number of ROM banks decoded from CPU address, held in block RAM and loaded at run time from the MiST download port, plus the work/video RAM. It provides a load/clear/run sequencer that holds the CPU in wait during loading and zeroes work RAM before release. It also flags CPU writes into ROM space. It sits between the 8080 bus logic and the download controller in each game top level.

## Interface
- ROM_BANKS, 5: number of ROM banks (1..16).
- BANK_AW, 11: address width of one bank (bank size 2^BANK_AW bytes).
- BANK_SEL, {5'b01000,5'b00011,5'b00010,5'b00001,5'b00000}: packed ROM_BANKS×(16-BANK_AW)-bit vector; entry i is the Addr[15:BANK_AW] value selecting bank i.
- RAM_AW, 13: work RAM address width.
- DL_AW, 14: download address width; must be ≥ clog2(ROM_BANKS)+BANK_AW.
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Addr  in  16  CPU ROM address.
- RW_n  in  1  CPU write strobe, active low.
- Ram_Addr  in  16  CPU RAM address; bits [RAM_AW-1:0] used.
- Ram_in  in  8  CPU write data.
- Ram_out  out  8  RAM read data.
- Rom_out  out  8  ROM read data.
- Dl_active  in  1  download in progress.
- Dl_wr  in  1  download byte strobe, one cycle.
- Dl_addr  in  DL_AW  linear download byte address.
- Dl_data  in  8  download byte.
- Cpu_Wait  out  1  CPU hold request.
- Wp_viol  out  1  one-cycle pulse: CPU write to a mapped ROM address.
- Dl_overflow  out  1  sticky: download byte beyond ROM_BANKS×2^BANK_AW.

## Operation
- States: WAIT, LOAD, CLEAR, RUN. Reset → WAIT.
- WAIT: Dl_active=1 → LOAD.
- LOAD: each Dl_wr writes Dl_data to bank Dl_addr>>BANK_AW, offset Dl_addr[BANK_AW-1:0]; bytes with bank index ≥ ROM_BANKS discarded and set Dl_overflow. Dl_active=0 → CLEAR.
- CLEAR: counter sweeps RAM addresses 0..2^RAM_AW−1, writing 0x00, one per cycle; after the last address → RUN. Dl_active=1 during CLEAR aborts the sweep → LOAD (counter reset on the next CLEAR entry).
- RUN: CPU access enabled. Dl_active=1 → LOAD (re-download; Dl_overflow cleared on LOAD entry).
- Cpu_Wait = 1 in every state except RUN.
- ROM decode: Addr[15:BANK_AW] compared against each BANK_SEL entry; first match (lowest i) wins; no match → Rom_out 0x00. Rom_out is valid in all states; contents are undefined before the first load.
- RAM: CPU write when RW_n=0 and state RUN; writes outside RUN are ignored. CPU reads allowed in every state.
- Wp_viol: RW_n=0 in RUN with Addr matching any BANK_SEL entry; ROM contents unchanged.
- Dl_wr outside LOAD is ignored.

## Timing
- Rom_out: registered; data for the Addr sampled at edge N appears after edge N+1 (1-cycle latency), including 0x00 for unmapped addresses.
- Ram_out: 1-cycle latency. A read of the address just written returns the new data (write-first).
- Download write: takes effect at the edge where Dl_wr=1. A CPU read of the same byte issued at least one cycle later returns the new value.
- State transitions are registered. Cpu_Wait falls at the edge after the final clear write.
- CLEAR duration is exactly 2^RAM_AW cycles. Cpu_Wait rises at the edge where Dl_active is first sampled high.
- Wp_viol is registered, 1 cycle after the offending write.
- Reset values: state WAIT, Cpu_Wait 1, Rom_out 0x00, Ram_out 0x00, Wp_viol 0, Dl_overflow 0, clear counter 0. Memory contents are not reset.
- Reset asserted mid-LOAD or mid-CLEAR returns the block to WAIT. A fresh download is required to reach RUN.

## Structure
- Package mw8080_mem_pkg: state enum, clog2-derived bank-index width, and a default BANK_SEL constant for the 5-bank 2 KB layout.
- Sub-module dpram (existing): ROM store, ROM_BANKS×2^BANK_AW deep. Port A is the CPU read; port B is the download write.
- Sub-module spram (existing): work RAM. The address/data/wren mux selects between the CPU and the clear counter.

## Test plan
- Load 5 banks (Dl_addr 0..0x27FF, data = addr[7:0]^bank), then drop Dl_active → Cpu_Wait high for 8192 cycles, then low. Reads of 0x0005, 0x0805, 0x4005 return 0x05, 0x04, 0x01 one cycle later.
- RUN, Addr=0x2000 (unmapped) → Rom_out 0x00 one cycle later.
- Write Ram_Addr 0x1234=0xA5 before and after the clear → final read 0x00 before the clear; after the clear a write gives 0xA5 on the next cycle.
- RUN, RW_n=0 at Addr 0x0010 → Wp_viol single-cycle pulse; ROM byte unchanged.
- Dl_wr at Dl_addr 0x2800 → Dl_overflow=1; no bank modified. It clears on the next LOAD entry.
- Dl_active raised 100 cycles into CLEAR → LOAD immediately, Cpu_Wait stays 1. Reset mid-LOAD → WAIT, Cpu_Wait 1.

Source files
------------

// File: rtl/mw8080_rom_ram_map_pkg.sv
// Shared types and constants for the 8080 program-memory map.
package mw8080_mem_pkg;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_LOAD,
    ST_CLEAR,
    ST_RUN
  } state_t;

  function automatic int unsigned bank_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_BANKS   = 5;
  localparam int unsigned DEF_BANK_AW = 11;
  localparam logic [DEF_BANKS*(16-DEF_BANK_AW)-1:0] DEF_BANK_SEL =
    {5'b01000, 5'b00011, 5'b00010, 5'b00001, 5'b00000};

endpackage

// File: rtl/mw8080_rom_ram_map_if.sv
// CPU and download-port signals of the program-memory block.
interface mw8080_rom_ram_map_if #(
  parameter int unsigned DL_AW = 14
);
  logic [15:0]      Addr;
  logic             RW_n;
  logic [15:0]      Ram_Addr;
  logic [7:0]       Ram_in;
  logic [7:0]       Ram_out;
  logic [7:0]       Rom_out;
  logic             Dl_active;
  logic             Dl_wr;
  logic [DL_AW-1:0] Dl_addr;
  logic [7:0]       Dl_data;
  logic             Cpu_Wait;
  logic             Wp_viol;
  logic             Dl_overflow;

  modport master (
    output Addr, RW_n, Ram_Addr, Ram_in, Dl_active, Dl_wr, Dl_addr, Dl_data,
    input  Ram_out, Rom_out, Cpu_Wait, Wp_viol, Dl_overflow
  );

  modport slave (
    input  Addr, RW_n, Ram_Addr, Ram_in, Dl_active, Dl_wr, Dl_addr, Dl_data,
    output Ram_out, Rom_out, Cpu_Wait, Wp_viol, Dl_overflow
  );
endinterface

// File: rtl/mw8080_rom_ram_map_mem.sv
// Block-RAM primitives: dual-port ROM store and write-first work RAM.
module dpram #(
  parameter int unsigned AW    = 14,
  parameter int unsigned DEPTH = 10240
) (
  input  logic          clk,
  input  logic [AW-1:0] a_addr,
  output logic [7:0]    a_q,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_d
);
  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    a_q <= r_mem[a_addr];
    if (b_we) r_mem[b_addr] <= b_d;
  end
endmodule

module spram #(
  parameter int unsigned AW = 13
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    d,
  input  logic          we,
  output logic [7:0]    q
);
  logic [7:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= d;
      q           <= d;
    end else begin
      q <= r_mem[addr];
    end
  end
endmodule

// File: rtl/mw8080_rom_ram_map.sv
// Program ROM banks, work RAM and the load/clear/run sequencer for 8080 cores.
module mw8080_rom_ram_map
  import mw8080_mem_pkg::*;
#(
  parameter int unsigned ROM_BANKS = DEF_BANKS,
  parameter int unsigned BANK_AW   = DEF_BANK_AW,
  parameter logic [ROM_BANKS*(16-BANK_AW)-1:0] BANK_SEL = DEF_BANK_SEL,
  parameter int unsigned RAM_AW    = 13,
  parameter int unsigned DL_AW     = 14
) (
  input logic                  Clock,
  input logic                  Reset,
  mw8080_rom_ram_map_if.slave  bus
);
  localparam int unsigned SW     = 16 - BANK_AW;
  localparam int unsigned BIW    = bank_idx_w(ROM_BANKS);
  localparam int unsigned ROM_AW = BIW + BANK_AW;

  state_t            r_state, w_next;
  logic [RAM_AW-1:0] r_clr_cnt;
  logic              r_rom_hit, r_ram_vld, r_wp, r_ovf;
  logic              w_hit, w_dl_oob, w_dl_we, w_ram_we;
  logic [BIW-1:0]    w_bank;
  logic [DL_AW-1:0]  w_dl_bank;
  logic [RAM_AW-1:0] w_ram_addr;
  logic [7:0]        w_ram_d, w_rom_q, w_ram_q;

  // Lowest-numbered matching bank wins when BANK_SEL entries overlap.
  always_comb begin
    w_hit  = 1'b0;
    w_bank = '0;
    for (int unsigned i = 0; i < ROM_BANKS; i++) begin
      if (!w_hit && bus.Addr[15:BANK_AW] == BANK_SEL[i*SW +: SW]) begin
        w_hit  = 1'b1;
        w_bank = i[BIW-1:0];
      end
    end
  end

  assign w_dl_bank = DL_AW'(bus.Dl_addr >> BANK_AW);
  assign w_dl_oob  = (w_dl_bank >= DL_AW'(ROM_BANKS));
  assign w_dl_we   = (r_state == ST_LOAD) && bus.Dl_wr && !w_dl_oob;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_WAIT:  if (bus.Dl_active) w_next = ST_LOAD;
      ST_LOAD:  if (!bus.Dl_active) w_next = ST_CLEAR;
      ST_CLEAR: begin
        if (bus.Dl_active)       w_next = ST_LOAD;
        else if (&r_clr_cnt)     w_next = ST_RUN;
      end
      ST_RUN:   if (bus.Dl_active) w_next = ST_LOAD;
      default:  w_next = ST_WAIT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= ST_WAIT;
      r_clr_cnt <= '0;
      r_rom_hit <= 1'b0;
      r_ram_vld <= 1'b0;
      r_wp      <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_clr_cnt <= (r_state == ST_CLEAR) ? r_clr_cnt + 1'b1 : '0;
      r_rom_hit <= w_hit;
      r_ram_vld <= 1'b1;
      r_wp      <= (r_state == ST_RUN) && !bus.RW_n && w_hit;
      if (r_state != ST_LOAD && w_next == ST_LOAD)
        r_ovf <= 1'b0;
      else if (r_state == ST_LOAD && bus.Dl_wr && w_dl_oob)
        r_ovf <= 1'b1;
    end
  end

  always_comb begin
    if (r_state == ST_CLEAR) begin
      w_ram_addr = r_clr_cnt;
      w_ram_d    = '0;
      w_ram_we   = 1'b1;
    end else begin
      w_ram_addr = bus.Ram_Addr[RAM_AW-1:0];
      w_ram_d    = bus.Ram_in;
      w_ram_we   = (r_state == ST_RUN) && !bus.RW_n;
    end
  end

  dpram #(.AW(ROM_AW), .DEPTH(ROM_BANKS * (2**BANK_AW))) u_rom (
    .clk    (Clock),
    .a_addr ({w_bank, bus.Addr[BANK_AW-1:0]}),
    .a_q    (w_rom_q),
    .b_we   (w_dl_we),
    .b_addr (bus.Dl_addr[ROM_AW-1:0]),
    .b_d    (bus.Dl_data)
  );

  spram #(.AW(RAM_AW)) u_ram (
    .clk  (Clock),
    .addr (w_ram_addr),
    .d    (w_ram_d),
    .we   (w_ram_we),
    .q    (w_ram_q)
  );

  assign bus.Rom_out     = r_rom_hit ? w_rom_q : 8'h00;
  assign bus.Ram_out     = r_ram_vld ? w_ram_q : 8'h00;
  assign bus.Cpu_Wait    = (r_state != ST_RUN);
  assign bus.Wp_viol     = r_wp;
  assign bus.Dl_overflow = r_ovf;
endmodule
